// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes instruction field sets into 32-bit ARM words and streams
// them into instruction memory through its write port.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start, finish       1-cycle pulses: begin a load at BASE_ADDR / stop accepting and drain
//   in_valid, in_ready  field-set handshake
//   in_mode .. in_operand  instruction fields (mode, opcode, S, I, cond, Rn, Rd, operand)
//   imem_we/addr/wdata  registered imem write port, one word per asserted cycle
//   busy, done, err     status: not idle / drain complete pulse / sticky illegal-set flag
//   word_count          words written since start
module instr_encoder_loader #(
  parameter int unsigned              FIFO_DEPTH = 4,
  parameter int unsigned              ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]        BASE_ADDR  = '0,
  parameter int unsigned              MEM_WORDS  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_mode,
  input  logic [3:0]        in_op_code,
  input  logic              in_S,
  input  logic              in_I,
  input  logic [3:0]        in_cond,
  input  logic [3:0]        in_rn,
  input  logic [3:0]        in_rd,
  input  logic [23:0]       in_operand,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] word_count
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e state_q, state_d;

  logic [31:0]       fifo_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   fifo_cnt_q;
  logic [ADDR_W-1:0] word_count_q;
  logic              err_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic [31:0]       enc;
  logic              legal;
  logic              legal_op;
  logic              s_bit;
  logic              fifo_full;
  logic              fifo_empty;
  logic [ADDR_W-1:0] reserved;
  logic              cap_ok;
  logic              accept;
  logic              push;
  logic              pop;
  logic              start_load;

  // ---------------------------------------------------------------------------
  // Field encoder
  // ---------------------------------------------------------------------------
  always_comb begin
    legal_op = 1'b0;
    case (in_op_code)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101, 4'b0110,
      4'b1000, 4'b1010, 4'b1100, 4'b1101, 4'b1111: legal_op = 1'b1;
      default:                                     legal_op = 1'b0;
    endcase
  end

  // TST and CMP only exist in flag-setting form, so force S for them.
  assign s_bit = in_S | (in_op_code == 4'b1010) | (in_op_code == 4'b1000);

  always_comb begin
    enc   = '0;
    legal = 1'b0;
    unique case (in_mode)
      2'b00: begin
        enc   = {in_cond, 2'b00, in_I, in_op_code, s_bit, in_rn, in_rd, in_operand[11:0]};
        legal = legal_op;
      end
      2'b01: begin
        // Pre-indexed, add offset, word, no writeback; S selects load vs store.
        enc   = {in_cond, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, in_S, in_rn, in_rd,
                 in_operand[11:0]};
        legal = 1'b1;
      end
      2'b10: begin
        enc   = {in_cond, 3'b101, 1'b0, in_operand};
        legal = 1'b1;
      end
      default: begin
        enc   = '0;
        legal = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Handshake and FIFO control
  // ---------------------------------------------------------------------------
  assign fifo_full  = (fifo_cnt_q == CntW'(FIFO_DEPTH));
  assign fifo_empty = (fifo_cnt_q == '0);
  // Words already written plus words queued; a popped word counts in word_count at once.
  assign reserved   = word_count_q + ADDR_W'(fifo_cnt_q);
  assign cap_ok     = (reserved < ADDR_W'(MEM_WORDS));

  assign in_ready   = (state_q == StRun) & ~fifo_full & cap_ok;
  assign accept     = in_valid & in_ready;
  assign push       = accept & legal;
  assign pop        = ~fifo_empty;
  assign start_load = (state_q == StIdle) & start;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StRun;
      end
      StRun: begin
        if (finish || (reserved == ADDR_W'(MEM_WORDS))) state_d = StDrain;
      end
      StDrain: begin
        if (fifo_empty && !we_q) begin
          state_d = StIdle;
          done    = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_cnt_q   <= '0;
      word_count_q <= '0;
      err_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= BASE_ADDR;
      wdata_q      <= '0;
    end else begin
      state_q <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      fifo_cnt_q <= fifo_cnt_q + 1'b1;
      else if (!push && pop) fifo_cnt_q <= fifo_cnt_q - 1'b1;

      we_q <= pop;
      if (pop) begin
        addr_q  <= BASE_ADDR + {word_count_q[ADDR_W-3:0], 2'b00};
        wdata_q <= fifo_q[rd_ptr_q];
      end

      if (start_load) begin
        word_count_q <= '0;
        err_q        <= 1'b0;
      end else begin
        if (pop)               word_count_q <= word_count_q + 1'b1;
        if (accept && !legal)  err_q        <= 1'b1;
      end
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= enc;
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign busy       = (state_q != StIdle);
  assign err        = err_q;
  assign word_count = word_count_q;

endmodule
